cmos_dvp_src: RTL and testbench

Synthesizable DVP (OV7670-style) byte-stream source emitting `vsync`, `href` and 8-bit `dout` as RGB565, high byte first. It is the transmitter for the camera-capture front end of the edge-detection pipeline. It drives the capture path on-board, with the real sensor disconnected, and serves as the stimulus model in capture and Sobel benches. Frames carry selectable test patterns, so VGA output and capture logic can be checked against known pixels.

---
 rtl/cmos_dvp_src_if.sv | 12 +
 rtl/cmos_dvp_src.sv | 154 +++++++++++++++
 tb/tb_cmos_dvp_src.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cmos_dvp_src_if.sv
// DVP byte-stream bundle: frame sync, line valid, pixel byte and end-of-frame pulse.
// Latency: none, plain wires between source and sink.
// Backpressure: none, DVP is a free-running push interface.
interface cmos_dvp_src_if;
    logic       vsync;
    logic       href;
    logic [7:0] dout;
    logic       frame_done;

    modport master (output vsync, href, dout, frame_done);
    modport slave  (input  vsync, href, dout, frame_done);
endinterface

// File: rtl/cmos_dvp_src.sv
// OV7670-style DVP source: RGB565 test patterns, high byte first, with vsync/href framing.
// Latency: every output is registered, one clock behind its state/counter decode.
// Backpressure: none; en is honoured only at frame boundaries, and pattern is latched on VSYNC entry.
module cmos_dvp_src #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         pattern,
    cmos_dvp_src_if.master     dvp
);
    localparam int L   = 2*H_ACTIVE + H_BLANK;
    localparam int HW  = (L > 1) ? $clog2(L) : 1;
    localparam int BW  = H_ACTIVE / 8;
    localparam int BCW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t         state;
    logic [HW-1:0]  h_cnt;
    logic [15:0]    v_cnt;
    logic [1:0]     pat_q;
    logic [BCW-1:0] bar_px;
    logic [2:0]     bar_idx;

    logic           vsync_q;
    logic           href_q;
    logic [7:0]     dout_q;
    logic           frame_done_q;

    logic           line_end;
    logic           last_line;
    logic           in_href;
    logic [15:0]    hc_ext;
    logic [15:0]    x;
    logic [7:0]     g;
    logic [15:0]    pixel;
    logic [7:0]     byte_val;

    assign dvp.vsync      = vsync_q;
    assign dvp.href       = href_q;
    assign dvp.dout       = dout_q;
    assign dvp.frame_done = frame_done_q;

    // Decode line/frame position and build the byte for the current column.
    always_comb begin
        hc_ext   = 16'(h_cnt);
        x        = hc_ext >> 1;
        g        = x[7:0];
        line_end = (h_cnt == HW'(L-1));
        in_href  = (state == S_ACTIVE) && (hc_ext < 16'(2*H_ACTIVE));
        last_line = 1'b0;
        case (state)
            S_VSYNC:  last_line = (v_cnt == 16'(VSYNC_LINES-1));
            S_VBACK:  last_line = (v_cnt == 16'(V_BACK-1));
            S_ACTIVE: last_line = (v_cnt == 16'(V_ACTIVE-1));
            S_VFRONT: last_line = (v_cnt == 16'(V_FRONT-1));
            default:  last_line = 1'b0;
        endcase
        pixel = 16'h0000;
        case (pat_q)
            2'd0: begin
                case (bar_idx)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = {g[7:3], g[7:2], g[7:3]};
            2'd2:    pixel = (x[3] ^ v_cnt[3]) ? 16'hFFFF : 16'h0000;
            default: pixel = 16'h0000;
        endcase
        if (pat_q == 2'd3)
            byte_val = hc_ext[7:0];
        else
            byte_val = h_cnt[0] ? pixel[7:0] : pixel[15:8];
    end

    // Frame FSM, h/v counters, bar-width counter and registered DVP outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            h_cnt        <= '0;
            v_cnt        <= '0;
            pat_q        <= 2'd0;
            bar_px       <= '0;
            bar_idx      <= 3'd0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            dout_q       <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            vsync_q      <= (state == S_VSYNC);
            href_q       <= in_href;
            dout_q       <= in_href ? byte_val : 8'h00;
            frame_done_q <= (state == S_VFRONT) && last_line && line_end;

            // Bars advance one index every BW pixels; cleared outside href so each line restarts at bar 0.
            if (!in_href) begin
                bar_px  <= '0;
                bar_idx <= 3'd0;
            end else if (h_cnt[0]) begin
                if (bar_px == BCW'(BW-1)) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + BCW'(1);
                end
            end

            if (state == S_IDLE) begin
                h_cnt <= '0;
                v_cnt <= '0;
                if (en) begin
                    state <= S_VSYNC;
                    pat_q <= pattern;
                end
            end else begin
                h_cnt <= line_end ? '0 : h_cnt + HW'(1);
                if (line_end) begin
                    if (last_line) begin
                        v_cnt <= '0;
                        case (state)
                            S_VSYNC:  state <= S_VBACK;
                            S_VBACK:  state <= S_ACTIVE;
                            S_ACTIVE: state <= S_VFRONT;
                            default: begin
                                if (en) begin
                                    state <= S_VSYNC;
                                    pat_q <= pattern;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
                        endcase
                    end else begin
                        v_cnt <= v_cnt + 16'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cmos_dvp_src.sv
// Bench for cmos_dvp_src with a small frame: L=40 clocks per line, 320-clock frames.
// Latency: outputs sampled on the falling edge, one cycle after the edge that produced them.
// Backpressure: not applicable; the bench only drives en/pattern/rst.
module tb_cmos_dvp_src;
    localparam int H_ACTIVE    = 16;
    localparam int H_BLANK     = 8;
    localparam int V_ACTIVE    = 4;
    localparam int VSYNC_LINES = 2;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int L           = 2*H_ACTIVE + H_BLANK;
    localparam int FRAME       = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * L;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] pattern;

    int n_vec = 0;
    int n_err = 0;

    cmos_dvp_src_if dvp();

    cmos_dvp_src #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern(pattern), .dvp(dvp)
    );

    always #5 clk = ~clk;

    // One comparison: count it, and report a miscompare with both values.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected byte at column col of active row y, straight from the pattern definitions.
    function automatic logic [7:0] model_byte(input int pat, input int col, input int y);
        int          x;
        logic [15:0] pw;
        logic [7:0]  g;
        logic [31:0] cv;
        x  = col / 2;
        g  = 8'(x);
        pw = 16'h0000;
        case (pat)
            0: begin
                case (x / (H_ACTIVE/8))
                    0:       pw = 16'hFFFF;
                    1:       pw = 16'hFFE0;
                    2:       pw = 16'h07FF;
                    3:       pw = 16'h07E0;
                    4:       pw = 16'hF81F;
                    5:       pw = 16'hF800;
                    6:       pw = 16'h001F;
                    default: pw = 16'h0000;
                endcase
            end
            1: pw = {g[7:3], g[7:2], g[7:3]};
            2: pw = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: pw = 16'h0000;
        endcase
        cv = col;
        if (pat == 3)
            return cv[7:0];
        return (col % 2 == 1) ? pw[7:0] : pw[15:8];
    endfunction

    // Check one whole frame cycle by cycle; optionally change inputs or assert reset mid-frame.
    task automatic run_frame(input int pat, input int chg_at, input int new_pat,
                             input bit new_en, input int abort_at);
        int   c0, ln, col;
        logic e_vs, e_hr, e_fd;
        logic [7:0] e_do;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            c0   = c - 1;
            ln   = c0 / L;
            col  = c0 % L;
            e_vs = (ln < VSYNC_LINES);
            e_hr = (ln >= VSYNC_LINES + V_BACK) && (ln < VSYNC_LINES + V_BACK + V_ACTIVE)
                   && (col < 2*H_ACTIVE);
            e_fd = (c == FRAME);
            e_do = e_hr ? model_byte(pat, col, ln - VSYNC_LINES - V_BACK) : 8'h00;
            chk($sformatf("vsync p%0d c%0d", pat, c), 32'(dvp.vsync), 32'(e_vs));
            chk($sformatf("href p%0d c%0d", pat, c), 32'(dvp.href), 32'(e_hr));
            chk($sformatf("dout p%0d c%0d", pat, c), 32'(dvp.dout), 32'(e_do));
            chk($sformatf("frame_done p%0d c%0d", pat, c), 32'(dvp.frame_done), 32'(e_fd));
            if (c == chg_at) begin
                pattern = 2'(new_pat);
                en      = new_en;
            end
            if (c == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort vsync", 32'(dvp.vsync), 32'd0);
                chk("abort href", 32'(dvp.href), 32'd0);
                chk("abort dout", 32'(dvp.dout), 32'd0);
                chk("abort frame_done", 32'(dvp.frame_done), 32'd0);
                break;
            end
        end
    endtask

    // Hold for n cycles and count any cycle where an output is not quiet.
    task automatic idle_check(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dvp.vsync !== 1'b0 || dvp.href !== 1'b0 || dvp.dout !== 8'h00
                || dvp.frame_done !== 1'b0)
                bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        pattern = 2'd0;
        repeat (5) @(negedge clk);
        chk("reset vsync", 32'(dvp.vsync), 32'd0);
        chk("reset href", 32'(dvp.href), 32'd0);
        chk("reset dout", 32'(dvp.dout), 32'd0);
        chk("reset frame_done", 32'(dvp.frame_done), 32'd0);
        rst = 1'b0;
        idle_check("idle_500", 500);

        // Start latency: vsync stays low one cycle after en is sampled.
        en      = 1'b1;
        pattern = 2'd3;
        @(negedge clk);
        chk("start_lat byte_cnt", 32'(dvp.vsync), 32'd0);
        run_frame(3, 300, 0, 1'b1, 0);
        run_frame(0, 300, 2, 1'b1, 0);
        run_frame(2, 300, 0, 1'b1, 0);
        // Pattern changed and en dropped mid-frame: frame stays bars and completes.
        run_frame(0, 100, 1, 1'b0, 0);
        idle_check("stop_idle", 100);

        en      = 1'b1;
        pattern = 2'd1;
        @(negedge clk);
        chk("start_lat gray", 32'(dvp.vsync), 32'd0);
        run_frame(1, 300, 2, 1'b1, 0);
        run_frame(2, 0, 2, 1'b1, 150);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("start_lat after_abort", 32'(dvp.vsync), 32'd0);
        run_frame(2, 300, 0, 1'b0, 0);
        idle_check("final_idle", 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
